// File: rtl/rsa_seq_pkg.sv
// Shared definitions for the RSA core enable/reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rsa_seq_pkg;

  // 3-bit state encoding; 3'd7 is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EOCP  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed by the phase down-counter to hold n-1 (at least 1).
  function automatic int unsigned ph_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rsa_seq_timer.sv
// Phase-length down-counter: load on state entry, count down on enabled cycles.
// Latency: done is valid the cycle after load; load takes priority over counting.
// Backpressure: en=0 holds the count, so a phase resumes where it stopped.
// Ports: clk, rst_n (async active-low), load/load_val (start a phase),
//        en (clock enable), done (count has reached zero).
module rsa_seq_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/rsa_seq_ctrl.sv
// RSA core enable/reset sequencer: start -> ARM -> RUN -> DRAIN -> EOCP -> HOLD -> IDLE.
// Latency: all outputs registered; en_rsa rises on the edge that samples start.
// Backpressure: ena=0 freezes state and outputs; stop_cmd aborts regardless of ena.
// Ports: clk, rstb (async active-low); ena, start, start_cmd, stop_cmd, eoc_int in;
//        en_rsa, rst_rsa (active-low), eoc (sticky), eocp (pulse), busy,
//        timeout_err (sticky), run_cycles (saturating RUN count) out.
// Build option: define RSA_SEQ_WDT_EN to enable the RUN watchdog and the ERR state.
module rsa_seq_ctrl
  import rsa_seq_pkg::*;
#(
  parameter int unsigned ARM_CYC     = 1,
  parameter int unsigned DRAIN_CYC   = 1,
  parameter int unsigned EOC_CYC     = 1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic             eoc_int,
  output logic             en_rsa,
  output logic             rst_rsa,
  output logic             eoc,
  output logic             eocp,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] run_cycles
);

  localparam int unsigned PH_W = ph_w(max3(ARM_CYC, DRAIN_CYC, EOC_CYC));
  localparam logic [PH_W-1:0] ARM_LD   = PH_W'(ARM_CYC - 1);
  localparam logic [PH_W-1:0] DRAIN_LD = PH_W'(DRAIN_CYC - 1);
  localparam logic [PH_W-1:0] EOC_LD   = PH_W'(EOC_CYC - 1);

`ifdef RSA_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             en_q, en_d, rst_q, rst_d, eoc_q, eoc_d, eocp_q, eocp_d;
  logic             busy_q, busy_d, terr_q, terr_d;
  logic [CNT_W-1:0] rc_q, rc_d, rc_inc;
  logic             go, wdt_exp, ph_done, ph_load;
  logic [PH_W-1:0]  ph_val;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    rst_d   = rst_q;
    eoc_d   = eoc_q;
    eocp_d  = eocp_q;
    terr_d  = terr_q;
    rc_d    = rc_q;
    go      = ena && (start || start_cmd);
    rc_inc  = (rc_q == {CNT_W{1'b1}}) ? rc_q : rc_q + 1'b1;
    // Expiry looks at the count this RUN cycle will produce, so a limit of N
    // trips on the Nth RUN cycle.
    wdt_exp = WDT_ON && (rc_inc >= CNT_W'(TIMEOUT_CYC));

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (go) begin
          state_d = ST_ARM;
          en_d    = 1'b1;
          rst_d   = 1'b0;
          eoc_d   = 1'b0;
          terr_d  = 1'b0;
          rc_d    = '0;
        end
      end
      ST_ARM: begin
        if (ena && ph_done) begin
          state_d = ST_RUN;
          rst_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (ena) begin
          rc_d = rc_inc;
          if (eoc_int) begin
            state_d = ST_DRAIN;
          end else if (wdt_exp) begin
            state_d = ST_ERR;
            en_d    = 1'b0;
            rst_d   = 1'b0;
            terr_d  = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (ena && ph_done) begin
          state_d = ST_EOCP;
          eocp_d  = 1'b1;
        end
      end
      ST_EOCP: begin
        if (ena) begin
          state_d = ST_HOLD;
          eocp_d  = 1'b0;
          eoc_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        // rst_rsa and eoc stay high into IDLE so the core result remains readable.
        if (ena && ph_done) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stop_cmd) begin
      state_d = ST_IDLE;
      en_d    = 1'b0;
      rst_d   = 1'b0;
      eoc_d   = 1'b0;
      eocp_d  = 1'b0;
      terr_d  = 1'b0;
      rc_d    = '0;
    end

    busy_d = (state_d inside {ST_ARM, ST_RUN, ST_DRAIN, ST_EOCP, ST_HOLD});

    // Reload the phase counter on every state change with the new phase length.
    ph_load = (state_d != state_q);
    case (state_d)
      ST_ARM:   ph_val = ARM_LD;
      ST_DRAIN: ph_val = DRAIN_LD;
      ST_HOLD:  ph_val = EOC_LD;
      default:  ph_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      rst_q   <= 1'b0;
      eoc_q   <= 1'b0;
      eocp_q  <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      eoc_q   <= eoc_d;
      eocp_q  <= eocp_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      rc_q    <= rc_d;
    end
  end

  rsa_seq_timer #(.W(PH_W)) u_timer (
    .clk      (clk),
    .rst_n    (rstb),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ena),
    .done     (ph_done)
  );

  assign en_rsa      = en_q;
  assign rst_rsa     = rst_q;
  assign eoc         = eoc_q;
  assign eocp        = eocp_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign run_cycles  = rc_q;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Bench for rsa_seq_ctrl: a default-parameter instance (watchdog limit 20) and a
// stretched-phase instance (ARM 4, DRAIN 3, EOC 5), selected by sel.
// Vector inputs are {ena,start,start_cmd,stop_cmd,eoc_int}; expected outputs are
// {en_rsa,rst_rsa,eoc,eocp,busy,timeout_err} plus run_cycles after the edge.
module tb_rsa_seq_ctrl;

  logic clk = 1'b0;
  logic rstb;
  logic sel;
  logic ena, start, start_cmd, stop_cmd, eoc_int;

  always #5 clk = ~clk;

  logic        en1, rs1, eoc1, eocp1, busy1, te1;
  logic        en2, rs2, eoc2, eocp2, busy2, te2;
  logic [15:0] rc1, rc2;

  rsa_seq_ctrl #(.TIMEOUT_CYC(20)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .start(start & ~sel), .start_cmd(start_cmd & ~sel),
    .stop_cmd(stop_cmd & ~sel), .eoc_int(eoc_int & ~sel),
    .en_rsa(en1), .rst_rsa(rs1), .eoc(eoc1), .eocp(eocp1),
    .busy(busy1), .timeout_err(te1), .run_cycles(rc1)
  );

  rsa_seq_ctrl #(.ARM_CYC(4), .DRAIN_CYC(3), .EOC_CYC(5)) dut2 (
    .clk(clk), .rstb(rstb), .ena(ena),
    .start(start & sel), .start_cmd(start_cmd & sel),
    .stop_cmd(stop_cmd & sel), .eoc_int(eoc_int & sel),
    .en_rsa(en2), .rst_rsa(rs2), .eoc(eoc2), .eocp(eocp2),
    .busy(busy2), .timeout_err(te2), .run_cycles(rc2)
  );

  logic [5:0]  obs_o;
  logic [15:0] obs_rc;
  always_comb begin
    obs_o  = sel ? {en2, rs2, eoc2, eocp2, busy2, te2} : {en1, rs1, eoc1, eocp1, busy1, te1};
    obs_rc = sel ? rc2 : rc1;
  end

  typedef struct {
    logic        sel;
    logic [4:0]  i;
    logic [5:0]  o;
    int          rc;
  } vec_t;

  typedef struct {
    logic [5:0]  o;
    logic [15:0] rc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic s, input logic [4:0] i, input logic [5:0] o, input int rc);
    vec_t v;
    v.sel = s; v.i = i; v.o = o; v.rc = rc;
    tbl.push_back(v);
  endtask

  task automatic check();
    exp_t e;
    e = sb.pop_front();
    n_vec++;
    if (obs_o !== e.o || obs_rc !== e.rc) begin
      n_err++;
      $display("FAIL vec%0d: {en,rst_rsa,eoc,eocp,busy,terr}=%b run_cycles=%0d, expected %b run_cycles=%0d",
               n_vec, obs_o, obs_rc, e.o, e.rc);
    end
  endtask

  task automatic expect_now(input logic [5:0] o, input int rc);
    exp_t e;
    e.o = o; e.rc = 16'(rc);
    sb.push_back(e);
    check();
  endtask

  task automatic step(input logic s, input logic [4:0] i, input logic [5:0] o, input int rc);
    exp_t e;
    @(negedge clk);
    sel = s;
    {ena, start, start_cmd, stop_cmd, eoc_int} = i;
    e.o = o; e.rc = 16'(rc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstb = 1'b0; sel = 1'b0;
    {ena, start, start_cmd, stop_cmd, eoc_int} = 5'b0;

    // ---- default instance: full run, eoc_int on RUN cycle 10 ----
    add(0, 5'b10000, 6'b000000, 0);
    add(0, 5'b11000, 6'b100010, 0);              // start -> ARM
    add(0, 5'b10000, 6'b110010, 0);              // RUN, core out of reset
    for (int k = 1; k <= 9; k++)
      add(0, (k == 4) ? 5'b10100 : (k == 6) ? 5'b11000 : 5'b10000, 6'b110010, k);
    add(0, 5'b10001, 6'b110010, 10);             // eoc_int -> DRAIN
    add(0, 5'b10000, 6'b110110, 10);             // eocp pulse
    add(0, 5'b10000, 6'b111010, 10);             // HOLD: eoc with en
    add(0, 5'b10100, 6'b011000, 10);             // start_cmd in HOLD ignored, IDLE
    add(0, 5'b10000, 6'b011000, 10);             // not queued
    add(0, 5'b10100, 6'b100010, 0);              // restart clears eoc/run_cycles
    add(0, 5'b10000, 6'b110010, 0);
    add(0, 5'b10000, 6'b110010, 1);
    add(0, 5'b10010, 6'b000000, 0);              // stop in RUN
    add(0, 5'b11010, 6'b000000, 0);              // start+stop: stop wins
    add(0, 5'b01010, 6'b000000, 0);
    add(0, 5'b11000, 6'b100010, 0);              // stop released, start sampled
    add(0, 5'b11010, 6'b000000, 0);              // stop in ARM with start held
    add(0, 5'b11000, 6'b100010, 0);
    add(0, 5'b01000, 6'b100010, 0);              // frozen in ARM
    add(0, 5'b10000, 6'b110010, 0);
    add(0, 5'b00010, 6'b000000, 0);              // stop while ena=0

    // ---- stretched instance: ena toggling in ARM and DRAIN ----
    add(1, 5'b10000, 6'b000000, 0);
    add(1, 5'b11000, 6'b100010, 0);
    for (int k = 1; k <= 4; k++) begin
      add(1, 5'b00000, 6'b100010, 0);
      add(1, 5'b10000, (k < 4) ? 6'b100010 : 6'b110010, 0);
    end
    add(1, 5'b10000, 6'b110010, 1);
    add(1, 5'b00000, 6'b110010, 1);              // RUN count frozen
    add(1, 5'b10000, 6'b110010, 2);
    add(1, 5'b10001, 6'b110010, 3);              // eoc_int -> DRAIN
    for (int k = 1; k <= 3; k++) begin
      add(1, 5'b00000, 6'b110010, 3);
      add(1, 5'b10000, (k < 3) ? 6'b110010 : 6'b110110, 3);
    end
    add(1, 5'b00000, 6'b110110, 3);              // eocp held while frozen
    add(1, 5'b10000, 6'b111010, 3);
    for (int k = 1; k <= 5; k++)
      add(1, 5'b10000, (k < 5) ? 6'b111010 : 6'b011000, 3);
    add(1, 5'b10000, 6'b011000, 3);

    repeat (2) @(posedge clk);
    #1;
    expect_now(6'b000000, 0);                    // reset state, default instance
    sel = 1'b1; #1;
    expect_now(6'b000000, 0);                    // reset state, stretched instance
    sel = 1'b0;
    @(negedge clk);
    rstb = 1'b1;

    for (int k = 0; k < tbl.size(); k++)
      step(tbl[k].sel, tbl[k].i, tbl[k].o, tbl[k].rc);

`ifdef RSA_SEQ_WDT_EN
    // Watchdog expiry after 20 RUN cycles, then recovery by a new start.
    step(0, 5'b11000, 6'b100010, 0);
    step(0, 5'b10000, 6'b110010, 0);
    for (int k = 1; k <= 19; k++) step(0, 5'b10000, 6'b110010, k);
    step(0, 5'b10000, 6'b000001, 20);            // ERR
    step(0, 5'b10000, 6'b000001, 20);
    step(0, 5'b11000, 6'b100010, 0);             // start clears the flag
    step(0, 5'b10000, 6'b110010, 0);
    for (int k = 1; k <= 19; k++) step(0, 5'b10000, 6'b110010, k);
    step(0, 5'b10001, 6'b110010, 20);            // eoc_int beats expiry
    step(0, 5'b10000, 6'b110110, 20);
    step(0, 5'b10000, 6'b111010, 20);
    step(0, 5'b10000, 6'b011000, 20);
`else
    // No watchdog: RUN outlasts the configured limit and completes normally.
    step(0, 5'b11000, 6'b100010, 0);
    step(0, 5'b10000, 6'b110010, 0);
    for (int k = 1; k <= 24; k++) step(0, 5'b10000, 6'b110010, k);
    step(0, 5'b10001, 6'b110010, 25);
    step(0, 5'b10000, 6'b110110, 25);
    step(0, 5'b10000, 6'b111010, 25);
    step(0, 5'b10000, 6'b011000, 25);
`endif

    // Asynchronous reset in the middle of RUN.
    step(0, 5'b11000, 6'b100010, 0);
    step(0, 5'b10000, 6'b110010, 0);
    step(0, 5'b10000, 6'b110010, 1);
    @(negedge clk);
    rstb = 1'b0;
    #1;
    expect_now(6'b000000, 0);
    @(negedge clk);
    rstb = 1'b1;
    step(0, 5'b10000, 6'b000000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_seq_ctrl.md
Name: rsa_seq_ctrl

Overview:
Parametrised successor to the RSA core enable/reset sequencer. It accepts a start request from a pin or a register command and drives the core's enable and active-low reset in order. It waits for the core's end-of-conversion, then produces a one-cycle pre-EOC pulse and a sticky EOC flag. It adds programmable phase lengths, a RUN-cycle counter, busy status, a synchronous abort and an optional watchdog. It sits between the host/SPI register block and the RSA datapath core.

Parameters:
ARM_CYC, 1, cycles en_rsa=1 with core held in reset before release (>=1)
DRAIN_CYC, 1, cycles after eoc_int before the eocp pulse (>=1)
EOC_CYC, 1, cycles en_rsa stays high with eoc=1 before returning to IDLE (>=1)
CNT_W, 16, width of the RUN-cycle counter and watchdog compare
TIMEOUT_CYC, 65535, watchdog limit in RUN cycles (<=2^CNT_W-1; used only with the macro)

Ports:
clk  input  1  system clock, all logic on rising edge
rstb  input  1  asynchronous active-low reset
ena  input  1  clock enable; 0 freezes all state, counters and outputs
start  input  1  start request from pin, level-sampled
start_cmd  input  1  start request from register, level-sampled
stop_cmd  input  1  synchronous abort, independent of ena
eoc_int  input  1  end-of-conversion from core, level-sampled
en_rsa  output  1  core enable
rst_rsa  output  1  core reset, active-low (0 = core in reset)
eoc  output  1  end of conversion, sticky
eocp  output  1  one-cycle pre-EOC pulse
busy  output  1  1 in every state except IDLE and ERR
timeout_err  output  1  watchdog expiry flag, sticky
run_cycles  output  CNT_W  cycles spent in the last or current RUN, saturating

Behaviour:
- All outputs are registered. On rstb=0 every output is 0 and the state is IDLE.
- States: IDLE, ARM, RUN, DRAIN, EOCP, HOLD, ERR. A phase counter loads on each state entry and advances only when ena=1.
- IDLE: en=0, rst_rsa=0 after reset. After a completed run, rst_rsa=1 and eoc=1 remain. When ena=1 and (start|start_cmd)=1, go to ARM and clear eoc, timeout_err and run_cycles.
- ARM: en=1, rst_rsa=0 for ARM_CYC enabled cycles, then go to RUN. eoc_int is ignored in ARM.
- RUN: en=1, rst_rsa=1. run_cycles increments per enabled cycle and saturates at 2^CNT_W-1. When eoc_int=1, go to DRAIN.
- DRAIN: en=1, rst_rsa=1 for DRAIN_CYC cycles, then go to EOCP.
- EOCP: eocp=1 for exactly one enabled cycle, then go to HOLD.
- HOLD: eoc=1, en=1 for EOC_CYC cycles, then go to IDLE with en=0, rst_rsa=1, eoc=1. eoc stays at 1 until the next accepted start.
- With default parameters, timing is identical to the previous-generation sequencer: 1 ARM, wait, 1 drain, 1 eocp, 1 eoc-with-en.
- Start requests while busy=1 are ignored and are not queued.
- stop_cmd=1 in any state: the next edge goes to IDLE and all outputs take their reset values, regardless of ena. When start and stop_cmd are both high, stop_cmd wins.
- ena=0 mid-phase: the phase counter holds and the phase resumes when ena returns. eocp stays high while frozen.
- From ERR, an accepted start goes to ARM.

Optional Feature:
Macro RSA_SEQ_WDT_EN.
- Defined: in RUN, when run_cycles reaches TIMEOUT_CYC with no eoc_int, go to ERR. In ERR, en=0, rst_rsa=0 and timeout_err=1, held until an accepted start or stop_cmd. If eoc_int and expiry occur on the same cycle, eoc_int wins and the next state is DRAIN.
- Undefined: RUN waits indefinitely, ERR is unreachable, timeout_err is tied to 0 and TIMEOUT_CYC is ignored.

Decomposition:
- Package rsa_seq_pkg: state encoding constants (3-bit) and the counter-width helper function.
- One sub-module rsa_seq_timer: loadable down-counter with enable and a done flag, instantiated once for phase lengths.
- run_cycles and the watchdog compare stay in the top module.

Test Plan:
- Defaults: pulse start for 1 cycle, eoc_int at RUN cycle 10 -> en rises 1 cycle after start; rst_rsa rises 1 cycle later; eocp high for 1 cycle 2 edges after eoc_int; eoc=1 then en=0 after 1 more cycle; run_cycles=10.
- ARM_CYC=4, DRAIN_CYC=3, EOC_CYC=5 -> rst_rsa low for 4 cycles with en=1; eocp 3 cycles after eoc_int; en drops 5 cycles after eoc rises.
- ena toggled 0/1 every cycle during ARM and DRAIN -> phase lengths counted only on ena=1 cycles; outputs frozen while ena=0.
- stop_cmd in RUN, and again with start held high -> next cycle all outputs 0, state IDLE; no restart until stop_cmd falls and start is sampled.
- RSA_SEQ_WDT_EN with TIMEOUT_CYC=20 and no eoc_int -> timeout_err=1, en=0, rst_rsa=0 after 20 RUN cycles; a new start clears the flag. Repeat with eoc_int on cycle 20 -> normal completion.
- start_cmd pulsed during RUN and HOLD -> ignored; after IDLE with eoc=1, a new start clears eoc on the next edge.
